// File: rtl/rst_seq.sv
// rst_seq: reset sequencer for domains that share one clock.
// It merges the system reset with a synchronised user reset request and holds the
// affected outputs low for at least HOLD cycles. It then releases the outputs one
// at a time in ascending index order, GAP cycles apart.
// cause records whether the most recent sequence came from rst (0) or from usr_rst (1).
module rst_seq #(
    parameter int N_OUT                  = 4,
    parameter int HOLD                   = 16,
    parameter int GAP                    = 8,
    parameter int SYNC_STAGES            = 2,
    parameter logic [N_OUT-1:0] USR_MASK = {N_OUT{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             usr_rst,
    output logic [N_OUT-1:0] rstn,
    output logic             ready,
    output logic             cause,
    output logic             busy
);

    localparam int CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   usr_req;

    logic [N_OUT-1:0]       pending;
    logic [N_OUT-1:0]       first_oh;
    logic [N_OUT-1:0]       rest;
    logic                   have_pending;
    logic                   is_last;
    logic [CNT_W-1:0]       cnt_inc;

    // Bring the asynchronous user request into the clock domain; the last stage is usr_req.
    // NOTE: flops are written with <= so every stage samples the value from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], usr_rst};
        end
    end

    assign usr_req = sync_q[SYNC_STAGES-1];

    // A channel that still reads 0 is waiting for release. The lowest one goes next.
    // Channels already at 1 are skipped and use up no gap. This covers masked user
    // sequences and any channels left unreleased when a sequence was interrupted.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        pending      = ~rstn;
        first_oh     = pending & (~pending + N_OUT'(1));
        rest         = pending & ~first_oh;
        have_pending = |pending;
        is_last      = ~|rest;
        cnt_inc      = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
    end

    // Sequencer FSM: hold, staggered release, run. Every output is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ASSERT;
            cnt   <= '0;
            rstn  <= '0;
            ready <= 1'b0;
            cause <= 1'b0;
            busy  <= 1'b1;
        end else if (usr_req && state != ST_ASSERT) begin
            // A user request outside the hold restarts the whole sequence.
            state <= ST_ASSERT;
            cnt   <= '0;
            rstn  <= rstn & ~USR_MASK;
            ready <= 1'b0;
            cause <= 1'b1;
            busy  <= 1'b1;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (usr_req) begin
                        // The hold counts from the first cycle in which the request is gone.
                        cnt <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        cnt  <= '0;
                        rstn <= rstn | first_oh;
                        if (have_pending && is_last) begin
                            state <= ST_RUN;
                            ready <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_RELEASE;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                ST_RELEASE: begin
                    if (!have_pending) begin
                        // Reached only when the hold ended with nothing to release (empty mask).
                        state <= ST_RUN;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end else if (cnt == GAP_LAST) begin
                        cnt  <= '0;
                        rstn <= rstn | first_oh;
                        if (is_last) begin
                            state <= ST_RUN;
                            ready <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                ST_RUN: begin
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= ST_ASSERT;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: drives three rst_seq instances from one set of inputs. The instances
// use USR_MASK = 1111, 1010 and 0000. An event-scheduled model is checked against
// every instance on every cycle. Hand-computed expectations pin the key edges.
module tb_rst_seq;

    localparam int HOLD = 16;
    localparam int GAP  = 8;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic usr_rst = 1'b0;

    logic [3:0] d_rstn [3];
    logic       d_ready [3];
    logic       d_cause [3];
    logic       d_busy [3];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    rst_seq #(.N_OUT(4), .HOLD(HOLD), .GAP(GAP), .SYNC_STAGES(SYNC), .USR_MASK(4'b1111)) dut_full (
        .clk(clk), .rst(rst), .usr_rst(usr_rst),
        .rstn(d_rstn[0]), .ready(d_ready[0]), .cause(d_cause[0]), .busy(d_busy[0])
    );

    rst_seq #(.N_OUT(4), .HOLD(HOLD), .GAP(GAP), .SYNC_STAGES(SYNC), .USR_MASK(4'b1010)) dut_part (
        .clk(clk), .rst(rst), .usr_rst(usr_rst),
        .rstn(d_rstn[1]), .ready(d_ready[1]), .cause(d_cause[1]), .busy(d_busy[1])
    );

    rst_seq #(.N_OUT(4), .HOLD(HOLD), .GAP(GAP), .SYNC_STAGES(SYNC), .USR_MASK(4'b0000)) dut_none (
        .clk(clk), .rst(rst), .usr_rst(usr_rst),
        .rstn(d_rstn[2]), .ready(d_ready[2]), .cause(d_cause[2]), .busy(d_busy[2])
    );

    function automatic logic [3:0] mask_of(input int i);
        case (i)
            0:       return 4'b1111;
            1:       return 4'b1010;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic int kth_bit(input logic [3:0] s, input int k);
        int c = 0;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) begin
                if (c == k) return b;
                c++;
            end
        end
        return 0;
    endfunction

    task automatic check(input string name, input int inst, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d cyc=%0d got=%b expected=%b", name, inst, cyc, got, exp);
        end
    endtask

    // Behavioural model. Every rst edge or acted-upon user request sets an anchor edge.
    // The hold ends HOLD edges after the anchor. The k-th channel still low at that point
    // is released k*GAP edges later.
    bit         hist [1024];
    int         last_rst = 0;
    logic [3:0] m_rstn [3];
    logic       m_ready [3];
    logic       m_cause [3];
    logic       m_busy [3];
    int         m_anchor [3];
    bit         m_seq [3];
    logic [3:0] m_pset [3];
    int         m_np [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_seq[i]    = 1'b0;
            m_anchor[i] = 0;
            m_np[i]     = 0;
        end
    end

    always @(posedge clk) begin : model
        int n;
        int d;
        int k;
        bit req;
        cyc++;
        n = cyc;
        hist[n] = usr_rst;
        if (rst) last_rst = n;
        req = (n >= SYNC + 1) && (n - SYNC > last_rst) && hist[n - SYNC];
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_rstn[i]   = 4'b0000;
                m_cause[i]  = 1'b0;
                m_ready[i]  = 1'b0;
                m_busy[i]   = 1'b1;
                m_anchor[i] = n;
                m_seq[i]    = 1'b1;
            end else if (req) begin
                if (!(m_seq[i] && n <= m_anchor[i] + HOLD)) begin
                    m_rstn[i]  = m_rstn[i] & ~mask_of(i);
                    m_cause[i] = 1'b1;
                    m_ready[i] = 1'b0;
                    m_busy[i]  = 1'b1;
                    m_seq[i]   = 1'b1;
                end
                m_anchor[i] = n;
            end else if (m_seq[i]) begin
                d = n - (m_anchor[i] + HOLD);
                if (d == 0) begin
                    m_pset[i] = ~m_rstn[i];
                    m_np[i]   = $countones(m_pset[i]);
                end
                if (d >= 0) begin
                    k = d / GAP;
                    if (m_np[i] == 0) begin
                        if (d == 1) begin
                            m_seq[i] = 1'b0; m_ready[i] = 1'b1; m_busy[i] = 1'b0;
                        end
                    end else if ((d % GAP) == 0 && k < m_np[i]) begin
                        m_rstn[i][kth_bit(m_pset[i], k)] = 1'b1;
                        if (k == m_np[i] - 1) begin
                            m_seq[i] = 1'b0; m_ready[i] = 1'b1; m_busy[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Compare every instance with the model on each falling edge.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int i = 0; i < 3; i++) begin
                check("rstn",  i, d_rstn[i],          m_rstn[i]);
                check("ready", i, {3'b000, d_ready[i]}, {3'b000, m_ready[i]});
                check("cause", i, {3'b000, d_cause[i]}, {3'b000, m_cause[i]});
                check("busy",  i, {3'b000, d_busy[i]},  {3'b000, m_busy[i]});
            end
        end
    end

    task automatic goto(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    initial begin
        // Power-up: rst is high on edges 1..5, so edge 5 is edge 0 of the sequence.
        goto(5);
        check("lit_reset_rstn",  0, d_rstn[0], 4'b0000);
        check("lit_reset_busy",  0, {3'b000, d_busy[0]}, 4'b0001);
        check("lit_reset_ready", 0, {3'b000, d_ready[0]}, 4'b0000);
        rst = 1'b0;
        goto(20);  check("lit_pu_hold",   0, d_rstn[0], 4'b0000);
        goto(21);  check("lit_pu_ch0",    0, d_rstn[0], 4'b0001);
        goto(29);  check("lit_pu_ch1",    0, d_rstn[0], 4'b0011);
        goto(37);  check("lit_pu_ch2",    0, d_rstn[0], 4'b0111);
        goto(44);  check("lit_pu_notrdy", 0, {3'b000, d_ready[0]}, 4'b0000);
        goto(45);
        check("lit_pu_ch3",   0, d_rstn[0], 4'b1111);
        check("lit_pu_ready", 0, {3'b000, d_ready[0]}, 4'b0001);
        check("lit_pu_busy",  0, {3'b000, d_busy[0]}, 4'b0000);
        check("lit_pu_cause", 0, {3'b000, d_cause[0]}, 4'b0000);

        // User reset in RUN: usr_rst is sampled high on edges 100..102.
        goto(99);  usr_rst = 1'b1;
        goto(101); check("lit_usr_before", 0, d_rstn[0], 4'b1111);
        goto(102);
        usr_rst = 1'b0;
        check("lit_usr_fall",     0, d_rstn[0], 4'b0000);
        check("lit_mask_fall",    1, d_rstn[1], 4'b0101);
        check("lit_none_rstn",    2, d_rstn[2], 4'b1111);
        check("lit_none_cause",   2, {3'b000, d_cause[2]}, 4'b0001);
        goto(119); check("lit_usr_hold",   0, d_rstn[0], 4'b0000);
        goto(120);
        check("lit_usr_ch0",      0, d_rstn[0], 4'b0001);
        check("lit_mask_ch1",     1, d_rstn[1], 4'b0111);
        check("lit_none_notrdy",  2, {3'b000, d_ready[2]}, 4'b0000);
        goto(121); check("lit_none_ready", 2, {3'b000, d_ready[2]}, 4'b0001);
        goto(128);
        check("lit_mask_ch3",     1, d_rstn[1], 4'b1111);
        check("lit_mask_ready",   1, {3'b000, d_ready[1]}, 4'b0001);
        goto(144);
        check("lit_usr_ready",    0, {3'b000, d_ready[0]}, 4'b0001);
        check("lit_usr_cause",    0, {3'b000, d_cause[0]}, 4'b0001);

        // Re-trigger in mid-release: the second request is seen at edge 228, while rstn is 0011.
        goto(199); usr_rst = 1'b1;
        goto(200); usr_rst = 1'b0;
        goto(225); usr_rst = 1'b1;
        goto(226); usr_rst = 1'b0;
        goto(227); check("lit_rt_before", 0, d_rstn[0], 4'b0011);
        goto(228); check("lit_rt_fall",   0, d_rstn[0], 4'b0000);
        goto(243); check("lit_rt_hold",   0, d_rstn[0], 4'b0000);
        goto(244); check("lit_rt_ch0",    0, d_rstn[0], 4'b0001);
        goto(268); check("lit_rt_ready",  0, {3'b000, d_ready[0]}, 4'b0001);

        // rst during a user hold, then a user request in the middle of the system release.
        goto(299); usr_rst = 1'b1;
        goto(300); usr_rst = 1'b0;
        goto(309); check("lit_rs_cause1", 0, {3'b000, d_cause[0]}, 4'b0001);
        rst = 1'b1;
        goto(310);
        check("lit_rs_cause0", 0, {3'b000, d_cause[0]}, 4'b0000);
        check("lit_rs_rstn",   1, d_rstn[1], 4'b0000);
        goto(311); rst = 1'b0;
        goto(327); check("lit_rs_ch0",  0, d_rstn[0], 4'b0001);
        goto(335); usr_rst = 1'b1;
        goto(336); usr_rst = 1'b0;
        goto(337); check("lit_mix_before", 1, d_rstn[1], 4'b0011);
        goto(338);
        check("lit_mix_fall",  1, d_rstn[1], 4'b0001);
        check("lit_mix_none",  2, d_rstn[2], 4'b0011);
        goto(354);
        check("lit_mix_ch1",   1, d_rstn[1], 4'b0011);
        check("lit_mix_none2", 2, d_rstn[2], 4'b0111);
        goto(370); check("lit_mix_ch3", 1, d_rstn[1], 4'b1111);
        goto(378); check("lit_mix_full", 0, d_rstn[0], 4'b1111);

        // Long request: usr_rst is sampled high on edges 400..449, so usr_req is last high at edge 451.
        goto(399); usr_rst = 1'b1;
        goto(449); usr_rst = 1'b0;
        goto(450); check("lit_long_busy", 0, {3'b000, d_busy[0]}, 4'b0001);
        goto(466); check("lit_long_hold", 0, d_rstn[0], 4'b0000);
        goto(467); check("lit_long_ch0",  0, d_rstn[0], 4'b0001);
        goto(491); check("lit_long_rdy",  0, {3'b000, d_ready[0]}, 4'b0001);

        // A glitch between two rising edges must go unseen.
        goto(500);
        @(posedge clk);
        #2 usr_rst = 1'b1;
        #2 usr_rst = 1'b0;
        goto(506);
        check("lit_glitch_rstn",  0, d_rstn[0], 4'b1111);
        check("lit_glitch_ready", 0, {3'b000, d_ready[0]}, 4'b0001);
        check("lit_glitch_mask",  1, d_rstn[1], 4'b1111);

        goto(510);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
